// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported instruction/data memory between the fetch stage
// and the memory stage of the five-stage pipeline. A four-state FSM picks a
// winner in IDLE, presents the request on the memory side in REQ, waits for
// read data in WAIT_RD and pulses the owner's done flag in DONE. The data port
// normally wins a simultaneous request; a starvation counter forces fetch to
// win after STARVE_LIM consecutive losses.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch read request (held until if_done)
//   if_done/if_rdata    fetch completion pulse and instruction word
//   if_stall            if_req & ~if_done (combinational)
//   dm_req/dm_we/
//   dm_addr/dm_wdata    data load/store request (held until dm_done)
//   dm_done/dm_rdata    data completion pulse and load data
//   dm_stall            dm_req & ~dm_done (combinational)
//   mem_req/mem_we/
//   mem_addr/mem_wdata  memory-side request, held until mem_gnt
//   mem_gnt             memory accepted the request
//   mem_rvalid/mem_rdata read data return
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } arbState_t;

   localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);

   arbState_t         state_r;
   arbState_t         nextState_s;
   logic              arbValid_s;
   logic              grantIf_s;
   logic              ownerIsIf_r;
   logic [3:0]        starveCnt_r;
   logic              memReq_r;
   logic              memWe_r;
   logic [ADDR_W-1:0] memAddr_r;
   logic [DATA_W-1:0] memWdata_r;
   logic              ifDone_r;
   logic              dmDone_r;
   logic [DATA_W-1:0] ifRdata_r;
   logic [DATA_W-1:0] dmRdata_r;

   // Next-state and arbitration decision
   always_comb begin
      nextState_s = state_r;
      arbValid_s  = 1'b0;
      grantIf_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (if_req || dm_req) begin
               nextState_s = REQ;
               arbValid_s  = 1'b1;
               // Fetch only wins a contested slot once it has been starved.
               if (if_req && dm_req) begin
                  grantIf_s = (starveCnt_r == STARVE_LIM_C);
               end else begin
                  grantIf_s = if_req;
               end
            end else begin
               nextState_s = IDLE;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               nextState_s = memWe_r ? DONE : WAIT_RD;
            end else begin
               nextState_s = REQ;
            end
         end
         WAIT_RD: begin
            if (mem_rvalid) begin
               nextState_s = DONE;
            end else begin
               nextState_s = WAIT_RD;
            end
         end
         DONE: begin
            // No arbitration here: the requester gets one cycle to retire.
            nextState_s = IDLE;
         end
         default: begin
            nextState_s = IDLE;
         end
      endcase
   end

   // State register, winner latch and starvation counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ownerIsIf_r <= 1'b0;
         starveCnt_r <= 4'd0;
         memWe_r     <= 1'b0;
         memAddr_r   <= {ADDR_W{1'b0}};
         memWdata_r  <= {DATA_W{1'b0}};
      end else begin
         state_r <= nextState_s;
         if (arbValid_s) begin
            ownerIsIf_r <= grantIf_s;
            memWe_r     <= grantIf_s ? 1'b0 : dm_we;
            memAddr_r   <= grantIf_s ? if_addr : dm_addr;
            memWdata_r  <= grantIf_s ? {DATA_W{1'b0}} : dm_wdata;
            if (grantIf_s) begin
               starveCnt_r <= 4'd0;
            end else if (if_req) begin
               starveCnt_r <= starveCnt_r + 4'd1;
            end else begin
               starveCnt_r <= starveCnt_r;
            end
         end
      end
   end

   // Registered memory request and done pulses, derived from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         memReq_r <= 1'b0;
         ifDone_r <= 1'b0;
         dmDone_r <= 1'b0;
      end else begin
         memReq_r <= (nextState_s == REQ);
         ifDone_r <= (nextState_s == DONE) && ownerIsIf_r;
         dmDone_r <= (nextState_s == DONE) && !ownerIsIf_r;
      end
   end

   // Read data capture into the owner's holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         ifRdata_r <= {DATA_W{1'b0}};
         dmRdata_r <= {DATA_W{1'b0}};
      end else if ((state_r == WAIT_RD) && mem_rvalid) begin
         if (ownerIsIf_r) begin
            ifRdata_r <= mem_rdata;
         end else begin
            dmRdata_r <= mem_rdata;
         end
      end
   end

   assign mem_req   = memReq_r;
   assign mem_we    = memWe_r;
   assign mem_addr  = memAddr_r;
   assign mem_wdata = memWdata_r;
   assign if_done   = ifDone_r;
   assign dm_done   = dmDone_r;
   assign if_rdata  = ifRdata_r;
   assign dm_rdata  = dmRdata_r;
   assign if_stall  = if_req & ~ifDone_r;
   assign dm_stall  = dm_req & ~dmDone_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Each task drives one scenario and
// compares DUT outputs against hand-computed values. Inputs change and outputs
// are sampled 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_done;
   logic [31:0] dm_rdata;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int errors;
   int checks;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
      .if_rdata(if_rdata), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = 32'h0; dm_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      tick(); tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL rst_done: got if=%b dm=%b want 0 0", if_done, dm_done); end
      checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got if=%h dm=%h want 0 0", if_rdata, dm_rdata); end
      checks++; if (if_stall !== 1'b1 || dm_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got if=%b dm=%b want 1 0", if_stall, dm_stall); end
      rst = 1'b0; if_req = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_idle: got mem_req=%b want 0", mem_req); end
   endtask

   task automatic test_fetch();
      if_req = 1'b1; if_addr = 32'h100;
      tick();  // cycle 1
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wdata !== 32'h0)
         begin errors++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b wd=%h want 1 100 0 0", mem_req, mem_addr, mem_we, mem_wdata); end
      checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall1: got %b want 1", if_stall); end
      mem_gnt = 1'b1;
      tick();  // cycle 2
      mem_gnt = 1'b0;
      checks++; if (mem_req !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL fetch_wait: got req=%b done=%b want 0 0", mem_req, if_done); end
      mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
      tick();  // cycle 3
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      checks++; if (if_done !== 1'b1 || dm_done !== 1'b0) begin errors++; $display("FAIL fetch_done: got if=%b dm=%b want 1 0", if_done, dm_done); end
      checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
      checks++; if (if_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall3: got %b want 0", if_stall); end
      if_req = 1'b0;
      tick();  // cycle 4
      checks++; if (if_done !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h00500093)
         begin errors++; $display("FAIL fetch_after: got done=%b req=%b rdata=%h want 0 0 00500093", if_done, mem_req, if_rdata); end
   endtask

   task automatic test_store();
      int pulses;
      pulses = 0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF || dm_done !== 1'b0)
            begin errors++; $display("FAIL store_hold%0d: got req=%b we=%b addr=%h wd=%h done=%b", i, mem_req, mem_we, mem_addr, mem_wdata, dm_done); end
         mem_gnt = (i == 4);
      end
      tick();
      mem_gnt = 1'b0;
      if (dm_done === 1'b1) pulses++;
      checks++; if (dm_done !== 1'b1 || mem_req !== 1'b0 || dm_stall !== 1'b0)
         begin errors++; $display("FAIL store_done: got done=%b req=%b stall=%b want 1 0 0", dm_done, mem_req, dm_stall); end
      checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", dm_rdata); end
      dm_req = 1'b0; dm_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (dm_done === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL store_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_starvation();
      int w;
      logic expIf;
      if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
      for (int k = 0; k < 10; k++) begin
         expIf = ((k % 5) == 4);
         w = 0;
         while (mem_req !== 1'b1 && w < 8) begin
            tick(); w++;
         end
         checks++; if (mem_addr !== (expIf ? 32'h200 : 32'h300) || mem_req !== 1'b1)
            begin errors++; $display("FAIL starve_grant%0d: got req=%b addr=%h want 1 %h", k, mem_req, mem_addr, expIf ? 32'h200 : 32'h300); end
         mem_gnt = 1'b1;
         tick();
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h10000000 + 32'(k);
         tick();
         mem_rvalid = 1'b0;
         checks++; if (if_done !== expIf || dm_done !== !expIf)
            begin errors++; $display("FAIL starve_done%0d: got if=%b dm=%b want %b %b", k, if_done, dm_done, expIf, !expIf); end
         checks++; if ((expIf ? if_rdata : dm_rdata) !== 32'h10000000 + 32'(k))
            begin errors++; $display("FAIL starve_rdata%0d: got if=%h dm=%h want %h", k, if_rdata, dm_rdata, 32'h10000000 + 32'(k)); end
      end
      if_req = 1'b0; dm_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      int overlap;
      overlap = 0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      tick();
      mem_gnt = 1'b1;
      tick();  // WAIT_RD
      mem_gnt = 1'b0;
      if_req = 1'b1; if_addr = 32'h104;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (mem_req !== 1'b0 || if_stall !== 1'b1)
            begin errors++; $display("FAIL b2b_wait%0d: got req=%b if_stall=%b want 0 1", i, mem_req, if_stall); end
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h0000A5A5;
      tick();  // DONE
      mem_rvalid = 1'b0;
      if (if_done && dm_done) overlap++;
      checks++; if (dm_done !== 1'b1 || if_done !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0000A5A5)
         begin errors++; $display("FAIL b2b_dm_done: got dm=%b if=%b req=%b rdata=%h", dm_done, if_done, mem_req, dm_rdata); end
      dm_req = 1'b0;
      tick();  // IDLE
      if (if_done && dm_done) overlap++;
      checks++; if (mem_req !== 1'b0 || if_done !== 1'b0 || dm_done !== 1'b0)
         begin errors++; $display("FAIL b2b_idle: got req=%b if=%b dm=%b want 0 0 0", mem_req, if_done, dm_done); end
      tick();  // REQ for fetch
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104)
         begin errors++; $display("FAIL b2b_if_issue: got req=%b addr=%h want 1 104", mem_req, mem_addr); end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00001111;
      tick();
      mem_rvalid = 1'b0;
      if (if_done && dm_done) overlap++;
      checks++; if (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== 32'h00001111)
         begin errors++; $display("FAIL b2b_if_done: got if=%b dm=%b rdata=%h", if_done, dm_done, if_rdata); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
      if_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_midflight();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
      tick();
      mem_gnt = 1'b1;
      tick();  // WAIT_RD
      mem_gnt = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
      rst = 1'b0; dm_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (if_done !== 1'b0 || dm_done !== 1'b0 || mem_req !== 1'b0)
         begin errors++; $display("FAIL rstmid_done: got if=%b dm=%b req=%b want 0 0 0", if_done, dm_done, mem_req); end
      tick();
      checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || dm_done !== 1'b0)
         begin errors++; $display("FAIL rstmid_rdata: got if=%h dm=%h done=%b want 0 0 0", if_rdata, dm_rdata, dm_done); end
   endtask

   task automatic test_spurious();
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF0000;
      tick(); tick();
      checks++; if (mem_req !== 1'b0 || if_done !== 1'b0 || dm_done !== 1'b0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0)
         begin errors++; $display("FAIL spur_idle: got req=%b if=%b dm=%b ifr=%h dmr=%h", mem_req, if_done, dm_done, if_rdata, dm_rdata); end
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
      tick();
      mem_gnt = 1'b1;
      tick();  // WAIT_RD, gnt kept high
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (mem_req !== 1'b0 || dm_done !== 1'b0)
            begin errors++; $display("FAIL spur_gnt%0d: got req=%b done=%b want 0 0", i, mem_req, dm_done); end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000CAFE;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (dm_done !== 1'b1 || dm_rdata !== 32'h0000CAFE)
         begin errors++; $display("FAIL spur_done: got done=%b rdata=%h want 1 0000cafe", dm_done, dm_rdata); end
      dm_req = 1'b0;
      tick();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_fetch();
      test_store();
      test_starvation();
      test_back_to_back();
      test_reset_midflight();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 ns");
      $fatal(1, "timeout");
   end

endmodule
